// File: rtl/uart_rx_line_buffer.sv
// uart_rx_line_buffer: receive byte FIFO with sticky overflow and optional EOL line count (UART_RX_LINE_COUNT_EN)
module uart_rx_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic [DEPTH_LOG2:0]   lines,
  output logic                  line_ready
);
  localparam logic [DEPTH_LOG2:0]   CONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PONE = 1;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic pop, push, drop;
  assign out_valid = level != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop  = out_valid & out_ready;
  // level never exceeds the depth, so its MSB alone means full
  assign push = in_valid & (~level[DEPTH_LOG2] | pop);
  assign drop = in_valid & ~push;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= push ? wr_ptr + PONE : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + PONE : rd_ptr;
      level    <= push & ~pop ? level + CONE : pop & ~push ? level - CONE : level;
      overflow <= drop | (overflow & ~clr_overflow);
    end
`ifdef UART_RX_LINE_COUNT_EN
  logic eol_in, eol_out;
  assign eol_in  = push & (in_data == EOL_CHAR);
  assign eol_out = pop & (out_data == EOL_CHAR);
  always_ff @(posedge clk or negedge rst)
    if (!rst) lines <= '0;
    else lines <= eol_in & ~eol_out ? lines + CONE : eol_out & ~eol_in ? lines - CONE : lines;
  assign line_ready = lines != '0;
`else
  assign lines      = '0;
  assign line_ready = 1'b0;
`endif
endmodule

// File: doc/uart_rx_line_buffer.md
Name: uart_rx_line_buffer

Overview:
- Receive-side byte buffer placed directly downstream of uart_rx.
- Captures each single-cycle data_valid/data_out pair from the receiver into a circular FIFO and presents bytes to the consumer (command parser / CPU bus bridge) over a valid/ready interface.
- Tracks how many complete lines, terminated by EOL_CHAR, are held, so the consumer can wait for a full command before draining.
- Reports dropped bytes via a sticky overflow flag.

Parameters:
DATA_WIDTH, 8, byte width; matches uart_rx data_width
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries)
EOL_CHAR, 8'h0D, byte value that terminates a line (CR)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_data  input  DATA_WIDTH  byte from uart_rx data_out
in_valid  input  1  one-cycle strobe from uart_rx data_valid; no backpressure possible
out_data  output  DATA_WIDTH  head-of-FIFO byte; 0 when out_valid=0
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts head byte when out_valid=1
level  output  DEPTH_LOG2+1  number of bytes stored, 0..2^DEPTH_LOG2
overflow  output  1  sticky: a byte was dropped because the FIFO was full
clr_overflow  input  1  one-cycle pulse clearing overflow
lines  output  DEPTH_LOG2+1  number of EOL_CHAR bytes currently stored
line_ready  output  1  lines != 0

Behaviour:
- Reset (rst=0, async assert, sync release): wr_ptr, rd_ptr, level, lines and overflow all 0. Consequently out_valid=0, out_data=0, line_ready=0. Storage array is not reset.
- pop = out_valid & out_ready.
- push = in_valid & (level < 2^DEPTH_LOG2 | pop).
  - A full FIFO with a simultaneous pop accepts the incoming byte.
- drop = in_valid & ~push. Sets overflow on the next edge.
  - clr_overflow clears overflow.
  - drop and clr_overflow in the same cycle: set wins.
- Fall-through output:
  - out_data = mem[rd_ptr], combinational from the registered array, gated to 0 when empty.
  - A byte pushed at edge N gives out_valid=1 in the cycle after edge N.
- Pointers are DEPTH_LOG2 bits wide and wrap from 2^DEPTH_LOG2-1 to 0 with no special casing.
- level: +1 on push only, -1 on pop only, unchanged on push and pop together.
  - Never exceeds 2^DEPTH_LOG2.
  - Never underflows: pop requires out_valid.
- Empty FIFO with in_valid: push only. Bytes do not bypass to the output in the same cycle.
- Bytes are delivered in arrival order; no byte is duplicated or reordered.
- Throughput: one push and one pop per cycle sustained.
- out_ready while out_valid=0: ignored.
- in_valid is a pulse: each high cycle is one byte, including back-to-back cycles.
- No internal state machine beyond the counters. Registered state is pointers, level, lines and overflow.

Optional Feature:
Macro: UART_RX_LINE_COUNT_EN
- Defined:
  - lines +1 when a pushed byte == EOL_CHAR.
  - lines -1 when a popped byte (out_data) == EOL_CHAR.
  - Both in the same cycle: lines unchanged.
  - Dropped EOL bytes are not counted.
  - line_ready = (lines != 0).
- Not defined: no comparison or line counter logic is built; lines is tied to 0 and line_ready is tied to 0. Ports remain present in both builds.

Test Plan:
1. Reset held, then released; push 8'h41, 8'h42, 8'h43 with out_ready=0. Expected: level=3, out_valid=1, out_data=8'h41; then out_ready=1 for 3 cycles yields 41, 42, 43, ending with level=0 and out_data=0.
2. Fill 16 bytes 8'h00..8'h0F with out_ready=0, then one more in_valid with 8'hFF. Expected: level=16, overflow=1, and the drained sequence is 00..0F with no FF; clr_overflow pulse then gives overflow=0.
3. FIFO full; in_valid with 8'h55 in the same cycle as a pop. Expected: level stays 16, overflow stays 0, and 8'h55 is the last byte drained.
4. With UART_RX_LINE_COUNT_EN defined: push "OK\r" and "GO\r" (4F 4B 0D 47 4F 0D). Expected: lines=2, line_ready=1; after popping the first 0D, lines=1; after the second, lines=0.
5. Reset asserted mid-stream at level=5 with out_ready=1, asynchronously between edges. Expected: level, lines and overflow are 0 and out_valid=0 immediately; after release, the first new push 8'h7E appears as out_data.
6. Continuous push and pop every cycle for 40 bytes (pointer wrap 2+ times) with an incrementing pattern. Expected: output matches input order, level stays at most 1, overflow=0.
